// File: rtl/ramdisk_pkg.sv
// Shared constants for the RAM-disk pointer controller: register offsets,
// step-mode encodings, sequencer states and the carry-compensation rule.
package ramdisk_pkg;

    localparam logic [1:0] OFS_L    = 2'd0;
    localparam logic [1:0] OFS_M    = 2'd1;
    localparam logic [1:0] OFS_H    = 2'd2;
    localparam logic [1:0] OFS_WIN  = 2'd3;
    localparam logic [3:0] REG_MODE = 4'hC;

    // Per-channel step mode; 2'b10 and 2'b11 both mean hold.
    localparam logic [1:0] STEP_INC = 2'b00;
    localparam logic [1:0] STEP_DEC = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SYNC   = 3'd1,
        S_STEP_M = 3'd2,
        S_STEP_H = 3'd3,
        S_EN     = 3'd4,
        S_DATA   = 3'd5,
        S_TAIL   = 3'd6,
        S_STALL  = 3'd7
    } seq_state_e;

    // A byte write that crosses bit 7 in the direction of travel owes a carry/borrow.
    function automatic logic comp_carry(input logic [1:0] mode, input logic old7, input logic new7);
        return ((mode == STEP_INC) && old7 && !new7) || ((mode == STEP_DEC) && !old7 && new7);
    endfunction

endpackage

// File: rtl/ramdisk_ptr_chan.sv
// One pointer channel: L/M/H bytes, pending step flags and latched direction.
// Ports: clk/rst, sequencer state s, channel mode, S5 strobes (step_req,
// wr_l/m/h) with write data din, and the assembled pointer ptr.
module ramdisk_ptr_chan
    import ramdisk_pkg::*;
#(
    parameter int unsigned ADDR_W = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  seq_state_e        s,
    input  logic [1:0]        mode,
    input  logic              step_req,
    input  logic              wr_l,
    input  logic              wr_m,
    input  logic              wr_h,
    input  logic [7:0]        din,
    output logic [ADDR_W-1:0] ptr
);
    localparam int unsigned HW = ADDR_W - 16;

    logic [7:0]    l_q, l_d, m_q, m_d;
    logic [HW-1:0] h_q, h_d;
    logic          pend_l_q, pend_l_d, pend_m_q, pend_m_d, pend_h_q, pend_h_d;
    logic          dir_q, dir_d;

    // Byte-serial step pipeline (S1..S3) plus S5 bus strobes.
    always_comb begin
        l_d      = l_q;
        m_d      = m_q;
        h_d      = h_q;
        pend_l_d = pend_l_q;
        pend_m_d = pend_m_q;
        pend_h_d = pend_h_q;
        dir_d    = dir_q;

        case (s)
            S_SYNC: if (pend_l_q) begin
                l_d      = dir_q ? l_q - 8'd1 : l_q + 8'd1;
                pend_l_d = 1'b0;
                if (l_q == (dir_q ? 8'h00 : 8'hFF)) pend_m_d = 1'b1;
            end
            S_STEP_M: if (pend_m_q) begin
                m_d      = dir_q ? m_q - 8'd1 : m_q + 8'd1;
                pend_m_d = 1'b0;
                if (m_q == (dir_q ? 8'h00 : 8'hFF)) pend_h_d = 1'b1;
            end
            S_STEP_H: if (pend_h_q) begin
                h_d      = dir_q ? h_q - HW'(1) : h_q + HW'(1);
                pend_h_d = 1'b0;
            end
            default: ;
        endcase

        // Direction is latched here so a later MODE write cannot redirect this step.
        if (step_req && (mode == STEP_INC || mode == STEP_DEC)) begin
            pend_l_d = 1'b1;
            dir_d    = (mode == STEP_DEC);
        end
        if (wr_l) begin
            l_d = din;
            if (comp_carry(mode, l_q[7], din[7])) begin
                pend_m_d = 1'b1;
                dir_d    = (mode == STEP_DEC);
            end
        end
        if (wr_m) begin
            m_d = din;
            if (comp_carry(mode, m_q[7], din[7])) begin
                pend_h_d = 1'b1;
                dir_d    = (mode == STEP_DEC);
            end
        end
        if (wr_h) begin
            h_d      = din[HW-1:0];
            pend_h_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            l_q      <= '0;
            m_q      <= '0;
            h_q      <= '0;
            pend_l_q <= 1'b0;
            pend_m_q <= 1'b0;
            pend_h_q <= 1'b0;
            dir_q    <= 1'b0;
        end else begin
            l_q      <= l_d;
            m_q      <= m_d;
            h_q      <= h_d;
            pend_l_q <= pend_l_d;
            pend_m_q <= pend_m_d;
            pend_h_q <= pend_h_d;
            dir_q    <= dir_d;
        end
    end

    assign ptr = {h_q, m_q, l_q};

endmodule

// File: rtl/ramdisk_ptr_ctrl.sv
// Multi-channel RAM-disk address-pointer controller for an Apple II slot card.
// Inputs: C7M clock, RES async reset, PHI1, nDEVSEL/nIOSEL/nWE, A[3:0], Din.
// Outputs: Dout/reg_rd register readback, RA SRAM address, RAMSEL/RAMCS window
// select, REGEN/CSDBEN enables and S (state counter, debug).
module ramdisk_ptr_ctrl
    import ramdisk_pkg::*;
#(
    parameter int unsigned ADDR_W = 20,
    parameter int unsigned NCH    = 2
) (
    input  logic              C7M,
    input  logic              RES,
    input  logic              PHI1,
    input  logic              nDEVSEL,
    input  logic              nIOSEL,
    input  logic              nWE,
    input  logic [3:0]        A,
    input  logic [7:0]        Din,
    output logic [7:0]        Dout,
    output logic              reg_rd,
    output logic [ADDR_W-1:0] RA,
    output logic              RAMSEL,
    output logic              RAMCS,
    output logic              REGEN,
    output logic              CSDBEN,
    output logic [2:0]        S
);
    localparam int unsigned MW = 2 * NCH;

    seq_state_e    s_q, s_d;
    logic          phi1_q, phi1_d, phi0seen_q, phi0seen_d;
    logic          regen_q, regen_d, csdben_q, csdben_d;
    logic [MW-1:0] mode_q, mode_d;
    logic [1:0]    last_ch_q, last_ch_d;

    logic [1:0]        ch, ofs;
    logic              ch_ok, sel, is_mode, win_hit, at_s5, wr_s5;
    logic [ADDR_W-1:0] ptr_all [4];
    logic [ADDR_W-1:0] ptr_sel;
    logic [7:0]        hi_rd;

    // Bus decode.
    assign ch      = A[3:2];
    assign ofs     = A[1:0];
    assign ch_ok   = 32'(ch) < NCH;
    assign sel     = regen_q & ~nDEVSEL;
    assign is_mode = (A == REG_MODE);
    assign win_hit = sel & ch_ok & (ofs == OFS_WIN);
    assign at_s5   = sel & (s_q == S_DATA);
    assign wr_s5   = at_s5 & ~nWE;

    // Channels; unused slots read as zero so the muxes stay fixed-width.
    for (genvar c = 0; c < 4; c++) begin : g_chan
        if (c < NCH) begin : g_used
            logic hit;
            assign hit = at_s5 & (ch == 2'(c));
            ramdisk_ptr_chan #(.ADDR_W(ADDR_W)) u_chan (
                .clk      (C7M),
                .rst      (RES),
                .s        (s_q),
                .mode     (mode_q[2*c +: 2]),
                .step_req (hit & (ofs == OFS_WIN)),
                .wr_l     (hit & ~nWE & (ofs == OFS_L)),
                .wr_m     (hit & ~nWE & (ofs == OFS_M)),
                .wr_h     (hit & ~nWE & (ofs == OFS_H)),
                .din      (Din),
                .ptr      (ptr_all[c])
            );
        end else begin : g_unused
            assign ptr_all[c] = '0;
        end
    end

    // Sequencer, enables, MODE register and last-channel tracking.
    always_comb begin
        s_d        = s_q;
        phi1_d     = PHI1;
        phi0seen_d = phi0seen_q | ~PHI1;
        csdben_d   = (s_q == S_EN) || (s_q == S_DATA) || (s_q == S_TAIL) || (s_q == S_STALL);
        regen_d    = regen_q | ((s_q == S_EN) & ~nIOSEL);
        mode_d     = mode_q;
        last_ch_d  = last_ch_q;

        // S saturates at 7 when the next PHI1 edge is late; 0 waits for the first edge.
        if (PHI1 && !phi1_q && phi0seen_q) begin
            s_d = S_SYNC;
        end else if (s_q != S_IDLE && s_q != S_STALL) begin
            s_d = seq_state_e'(s_q + 3'd1);
        end

        if (wr_s5 && is_mode) mode_d = Din[MW-1:0];
        if (at_s5 && win_hit) last_ch_d = ch;
    end

    always_ff @(posedge C7M or posedge RES) begin
        if (RES) begin
            s_q        <= S_IDLE;
            phi1_q     <= 1'b0;
            phi0seen_q <= 1'b0;
            regen_q    <= 1'b0;
            csdben_q   <= 1'b0;
            mode_q     <= '0;
            last_ch_q  <= '0;
        end else begin
            s_q        <= s_d;
            phi1_q     <= phi1_d;
            phi0seen_q <= phi0seen_d;
            regen_q    <= regen_d;
            csdben_q   <= csdben_d;
            mode_q     <= mode_d;
            last_ch_q  <= last_ch_d;
        end
    end

    // Register readback; the high byte is padded with ones above ADDR_W-16 bits.
    assign ptr_sel = ptr_all[ch];

    always_comb begin
        hi_rd                  = 8'hFF;
        hi_rd[ADDR_W-17:0]     = ptr_sel[ADDR_W-1:16];
    end

    always_comb begin
        Dout = 8'h00;
        if (is_mode) begin
            Dout = 8'(mode_q);
        end else if (ch_ok) begin
            case (ofs)
                OFS_L:   Dout = ptr_sel[7:0];
                OFS_M:   Dout = ptr_sel[15:8];
                OFS_H:   Dout = hi_rd;
                default: Dout = 8'h00;
            endcase
        end
    end

    assign RA     = win_hit ? ptr_sel : ptr_all[last_ch_q];
    assign RAMSEL = win_hit;
    assign RAMCS  = win_hit & csdben_q;
    assign reg_rd = sel & nWE & ~win_hit & csdben_q;
    assign REGEN  = regen_q;
    assign CSDBEN = csdben_q;
    assign S      = s_q;

endmodule

// File: tb/tb_ramdisk_ptr_ctrl.sv
module tb_ramdisk_ptr_ctrl;

    logic        C7M = 1'b0;
    logic        RES, PHI1, nDEVSEL, nIOSEL, nWE;
    logic [3:0]  A;
    logic [7:0]  Din, Dout;
    logic        reg_rd, RAMSEL, RAMCS, REGEN, CSDBEN;
    logic [19:0] RA;
    logic [2:0]  S;

    int checks = 0;
    int errors = 0;

    logic [2:0]  s_log   [14];
    logic        csd_log [14];
    logic        rsel_log[14];
    logic        rcs_log [14];
    logic        rrd_log [14];
    logic [7:0]  dout_log[14];
    logic [19:0] ra_log  [14];
    logic [7:0]  rd;

    ramdisk_ptr_ctrl #(.ADDR_W(20), .NCH(2)) dut (
        .C7M(C7M), .RES(RES), .PHI1(PHI1), .nDEVSEL(nDEVSEL), .nIOSEL(nIOSEL),
        .nWE(nWE), .A(A), .Din(Din), .Dout(Dout), .reg_rd(reg_rd), .RA(RA),
        .RAMSEL(RAMSEL), .RAMCS(RAMCS), .REGEN(REGEN), .CSDBEN(CSDBEN), .S(S)
    );

    always #5 C7M = ~C7M;

    // One 14-clock bus cycle: PHI1 high for 7 clocks, low for 7; bus held throughout.
    task automatic bus_cycle(input logic dsel_n, input logic iosel_n, input logic we_n,
                             input logic [3:0] a, input logic [7:0] d);
        for (int i = 0; i < 14; i++) begin
            PHI1 = (i < 7); nDEVSEL = dsel_n; nIOSEL = iosel_n; nWE = we_n; A = a; Din = d;
            @(posedge C7M); #1;
            s_log[i] = S; csd_log[i] = CSDBEN; rsel_log[i] = RAMSEL; rcs_log[i] = RAMCS;
            rrd_log[i] = reg_rd; dout_log[i] = Dout; ra_log[i] = RA;
        end
        nDEVSEL = 1'b1; nIOSEL = 1'b1; nWE = 1'b1;
    endtask

    task automatic write_reg(input logic [3:0] a, input logic [7:0] d);
        bus_cycle(1'b0, 1'b1, 1'b0, a, d);
    endtask

    task automatic read_reg(input logic [3:0] a, output logic [7:0] d);
        bus_cycle(1'b0, 1'b1, 1'b1, a, 8'h00);
        d = dout_log[5];
    endtask

    task automatic idle_cycle();
        bus_cycle(1'b1, 1'b1, 1'b1, 4'h0, 8'h00);
    endtask

    task automatic test_reset();
        RES = 1'b1; PHI1 = 1'b0; nDEVSEL = 1'b1; nIOSEL = 1'b1; nWE = 1'b1; A = 4'h0; Din = 8'h00;
        repeat (3) @(posedge C7M);
        #1;
        checks++; if (S !== 3'd0)    begin errors++; $display("FAIL reset_S got %0d exp 0", S); end
        checks++; if (REGEN !== 1'b0) begin errors++; $display("FAIL reset_REGEN got %b exp 0", REGEN); end
        checks++; if (CSDBEN !== 1'b0) begin errors++; $display("FAIL reset_CSDBEN got %b exp 0", CSDBEN); end
        checks++; if (RA !== 20'h0)  begin errors++; $display("FAIL reset_RA got %h exp 00000", RA); end
        RES = 1'b0;
        repeat (2) @(posedge C7M);
        #1;
    endtask

    task automatic test_sync_enable();
        bus_cycle(1'b1, 1'b0, 1'b1, 4'h0, 8'h00);
        for (int i = 0; i < 14; i++) begin
            checks++;
            if (s_log[i] !== ((i < 7) ? 3'(i + 1) : 3'd7)) begin
                errors++; $display("FAIL sync_S[%0d] got %0d exp %0d", i, s_log[i], (i < 7) ? i + 1 : 7);
            end
        end
        checks++; if (REGEN !== 1'b1) begin errors++; $display("FAIL sync_REGEN got %b exp 1", REGEN); end
        idle_cycle();
        checks++; if (s_log[0] !== 3'd1) begin errors++; $display("FAIL resync_S got %0d exp 1", s_log[0]); end
        for (int i = 0; i < 14; i++) begin
            checks++;
            if (csd_log[i] !== ((i == 0) || (i >= 4))) begin
                errors++; $display("FAIL csdben[%0d] got %b exp %b", i, csd_log[i], (i == 0) || (i >= 4));
            end
        end
    endtask

    task automatic test_inc_carry();
        write_reg(4'h4, 8'hFF);
        write_reg(4'h5, 8'hFF);
        write_reg(4'h6, 8'h00);
        write_reg(4'hC, 8'h00);
        read_reg(4'h7, rd);
        checks++; if (rsel_log[5] !== 1'b1) begin errors++; $display("FAIL inc_ramsel got %b exp 1", rsel_log[5]); end
        checks++; if (rcs_log[5] !== 1'b1)  begin errors++; $display("FAIL inc_ramcs got %b exp 1", rcs_log[5]); end
        checks++; if (rrd_log[5] !== 1'b0)  begin errors++; $display("FAIL inc_win_regrd got %b exp 0", rrd_log[5]); end
        checks++; if (ra_log[5] !== 20'h0FFFF) begin errors++; $display("FAIL inc_ra_win got %h exp 0ffff", ra_log[5]); end
        idle_cycle();
        checks++; if (ra_log[0] !== 20'h0FFFF) begin errors++; $display("FAIL inc_ra_s1 got %h exp 0ffff", ra_log[0]); end
        checks++; if (ra_log[1] !== 20'h0FF00) begin errors++; $display("FAIL inc_ra_l got %h exp 0ff00", ra_log[1]); end
        checks++; if (ra_log[2] !== 20'h00000) begin errors++; $display("FAIL inc_ra_m got %h exp 00000", ra_log[2]); end
        checks++; if (ra_log[3] !== 20'h10000) begin errors++; $display("FAIL inc_ra_h got %h exp 10000", ra_log[3]); end
        read_reg(4'h6, rd);
        checks++; if (rd !== 8'hF1) begin errors++; $display("FAIL inc_hi_read got %h exp f1", rd); end
        checks++; if (rrd_log[5] !== 1'b1) begin errors++; $display("FAIL inc_regrd got %b exp 1", rrd_log[5]); end
        read_reg(4'h4, rd);
        checks++; if (rd !== 8'h00) begin errors++; $display("FAIL inc_lo_read got %h exp 00", rd); end
    endtask

    task automatic test_dec_wrap();
        write_reg(4'hC, 8'h01);
        read_reg(4'h3, rd);
        idle_cycle();
        checks++; if (ra_log[13] !== 20'hFFFFF) begin errors++; $display("FAIL dec_ra got %h exp fffff", ra_log[13]); end
        read_reg(4'h0, rd);
        checks++; if (rd !== 8'hFF) begin errors++; $display("FAIL dec_lo got %h exp ff", rd); end
        read_reg(4'h1, rd);
        checks++; if (rd !== 8'hFF) begin errors++; $display("FAIL dec_mid got %h exp ff", rd); end
        read_reg(4'h2, rd);
        checks++; if (rd !== 8'hFF) begin errors++; $display("FAIL dec_hi got %h exp ff", rd); end
    endtask

    task automatic test_hold_latch();
        write_reg(4'hC, 8'h00);
        read_reg(4'h3, rd);
        write_reg(4'hC, 8'h02);
        checks++; if (ra_log[13] !== 20'h00000) begin errors++; $display("FAIL hold_step_once got %h exp 00000", ra_log[13]); end
        read_reg(4'h3, rd);
        idle_cycle();
        checks++; if (ra_log[13] !== 20'h00000) begin errors++; $display("FAIL hold_no_step got %h exp 00000", ra_log[13]); end
        read_reg(4'h2, rd);
        checks++; if (rd !== 8'hF0) begin errors++; $display("FAIL hold_hi got %h exp f0", rd); end
        read_reg(4'hC, rd);
        checks++; if (rd !== 8'h02) begin errors++; $display("FAIL hold_mode got %h exp 02", rd); end
    endtask

    task automatic test_carry_comp();
        write_reg(4'hC, 8'h00);
        write_reg(4'h1, 8'h12);
        write_reg(4'h0, 8'h80);
        write_reg(4'h0, 8'h00);
        read_reg(4'h1, rd);
        checks++; if (rd !== 8'h13) begin errors++; $display("FAIL comp_inc_m got %h exp 13", rd); end
        write_reg(4'hC, 8'h01);
        write_reg(4'h0, 8'h7F);
        write_reg(4'h0, 8'h80);
        read_reg(4'h1, rd);
        checks++; if (rd !== 8'h12) begin errors++; $display("FAIL comp_dec_m got %h exp 12", rd); end
        read_reg(4'h0, rd);
        checks++; if (rd !== 8'h80) begin errors++; $display("FAIL comp_dec_l got %h exp 80", rd); end
    endtask

    task automatic test_unmapped();
        logic [3:0] addrs [6];
        addrs = '{4'h8, 4'h9, 4'hA, 4'hB, 4'hD, 4'hE};
        for (int k = 0; k < 6; k++) begin
            write_reg(addrs[k], 8'h55);
            checks++; if (ra_log[13] !== 20'h01280) begin errors++; $display("FAIL unmap_ra[%h] got %h exp 01280", addrs[k], ra_log[13]); end
            read_reg(addrs[k], rd);
            checks++; if (rd !== 8'h00) begin errors++; $display("FAIL unmap_dout[%h] got %h exp 00", addrs[k], rd); end
            checks++; if (rsel_log[5] !== 1'b0) begin errors++; $display("FAIL unmap_ramsel[%h] got %b exp 0", addrs[k], rsel_log[5]); end
        end
        read_reg(4'h4, rd);
        checks++; if (rd !== 8'h00) begin errors++; $display("FAIL unmap_ch1_lo got %h exp 00", rd); end
        read_reg(4'h6, rd);
        checks++; if (rd !== 8'hF1) begin errors++; $display("FAIL unmap_ch1_hi got %h exp f1", rd); end
        read_reg(4'hC, rd);
        checks++; if (rd !== 8'h01) begin errors++; $display("FAIL unmap_mode got %h exp 01", rd); end
        write_reg(4'hC, 8'hFF);
        read_reg(4'hC, rd);
        checks++; if (rd !== 8'h0F) begin errors++; $display("FAIL mode_unused_bits got %h exp 0f", rd); end
    endtask

    task automatic test_reset_mid_step();
        write_reg(4'hC, 8'h00);
        write_reg(4'h0, 8'hFF);
        read_reg(4'h3, rd);
        PHI1 = 1'b1;
        repeat (2) begin @(posedge C7M); #1; end
        checks++; if (RA !== 20'h01200) begin errors++; $display("FAIL midstep_ra got %h exp 01200", RA); end
        RES = 1'b1; PHI1 = 1'b0;
        #1;
        checks++; if (RA !== 20'h00000) begin errors++; $display("FAIL rst_ra got %h exp 00000", RA); end
        checks++; if (REGEN !== 1'b0)   begin errors++; $display("FAIL rst_regen got %b exp 0", REGEN); end
        @(posedge C7M); #1;
        RES = 1'b0;
        repeat (2) begin @(posedge C7M); #1; end
        bus_cycle(1'b1, 1'b0, 1'b1, 4'h0, 8'h00);
        idle_cycle();
        checks++; if (ra_log[13] !== 20'h00000) begin errors++; $display("FAIL rst_no_step got %h exp 00000", ra_log[13]); end
        read_reg(4'h1, rd);
        checks++; if (rd !== 8'h00) begin errors++; $display("FAIL rst_ch0_mid got %h exp 00", rd); end
        read_reg(4'h6, rd);
        checks++; if (rd !== 8'hF0) begin errors++; $display("FAIL rst_ch1_hi got %h exp f0", rd); end
    endtask

    initial begin
        test_reset();
        test_sync_enable();
        test_inc_carry();
        test_dec_wrap();
        test_hold_latch();
        test_carry_comp();
        test_unmapped();
        test_reset_mid_step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ramdisk_ptr_ctrl.md
Name: ramdisk_ptr_ctrl

Overview:
- Multi-channel, parametrised RAM-disk address-pointer controller for the Apple II slot card.
- Sits between the slot bus decode (nDEVSEL/nIOSEL, A[3:0], nWE, D) and the SRAM address/chip-select pins.
- Generalises the single 20-bit auto-increment pointer to NCH independent pointers of ADDR_W bits, each with a per-channel step mode: +1, -1 or hold.
- Keeps the PHI1-synchronised 7M state counter and the byte-serial carry/borrow pipeline.

Parameters:
- ADDR_W, 20: pointer width; legal range 17..24. The high byte holds ADDR_W-16 bits.
- NCH, 2: number of pointer channels; legal range 1..3.

Ports:
- C7M  in  1  7M bus clock; all state updates on its rising edge.
- RES  in  1  reset; asynchronous, active-high.
- PHI1  in  1  PHI1, already hold-time delayed.
- nDEVSEL  in  1  slot device select, active low.
- nIOSEL  in  1  slot I/O select, active low.
- nWE  in  1  6502 R/W; low means write.
- A  in  4  address bits A[3:0].
- Din  in  8  Apple data bus, input side.
- Dout  out  8  register readback data.
- reg_rd  out  1  high when Dout is to drive D: REGEN & ~nDEVSEL & nWE & non-window register hit & CSDBEN.
- RA  out  ADDR_W  SRAM address.
- RAMSEL  out  1  data-window hit: REGEN & ~nDEVSEL & A[1:0]==3 & A[3:2]<NCH.
- RAMCS  out  1  RAMSEL & CSDBEN.
- REGEN  out  1  register-enable flag.
- CSDBEN  out  1  chip-select / data-bus-enable window.
- S  out  3  state counter, exported for debug.

Behaviour:
- Reset: while RES is high, S=0, PHI1reg=0, PHI0seen=0, REGEN=0, CSDBEN=0, all pointers=0, MODE=0, all pending flags=0, last_ch=0.
- Sequencer:
  - PHI1reg<=PHI1.
  - PHI0seen<=1 whenever PHI1 is low.
  - S<=1 when PHI1 & ~PHI1reg & PHI0seen. Otherwise S holds at 0 and at 7, and else increments.
  - S reaches 7 only on a stalled or missing PHI1 edge, and it saturates there.
- CSDBEN is registered: CSDBEN<=(S in 4..7).
- REGEN<=1 at S==4 when nIOSEL is low. REGEN is cleared only by reset.
- Register map, channel c = A[3:2] for c<NCH:
  - A[1:0]=0: pointer low byte, bits 7:0.
  - A[1:0]=1: pointer mid byte, bits 15:8.
  - A[1:0]=2: pointer high byte, bits ADDR_W-1:16. Reads pad the upper bits with 1s.
  - A[1:0]=3: data window.
- Register 0xC is MODE. Bits [2c+1:2c] select the step for channel c: 00 = +1, 01 = -1, 10 or 11 = hold. Unused MODE bits read 0.
- Registers 0xD-0xF, and any channel slot at or above NCH: reads return 0x00, writes are ignored.
- Writes (nWE low, ~nDEVSEL, REGEN) are captured at S==5 from Din.
- Window access at S==5: set pend_L[c]=1 and latch step_dir[c] from MODE at that moment. A later MODE change does not affect this pending step. Hold mode sets no pending flag.
- Step pipeline per channel, in the following cycle:
  - S==1 with pend_L: L<=L±1. Set pend_M if L was FF (increment) or 00 (decrement).
  - S==2 with pend_M: M<=M±1. Set pend_H on the same FF/00 rule.
  - S==3 with pend_H: H<=H±1, wrapping modulo 2^(ADDR_W-16).
  - Each flag clears when it is consumed.
- Full wrap: increment of all-ones gives 0; decrement of 0 gives all-ones.
- Carry compensation at S==5, for software that writes L after the step has already happened:
  - Increment mode: writing L with old L[7]=1 and Din[7]=0 sets pend_M.
  - Decrement mode: writing L with old L[7]=0 and Din[7]=1 sets pend_M.
  - Writing M follows the same rule using M[7] and sets pend_H.
  - Writing H clears pend_H.
- A direct byte write at S5 overrides that byte. Pending flags from the previous cycle have already drained by S5.
- RA:
  - When RAMSEL is high: RA = pointer[A[3:2]].
  - Otherwise: RA = pointer[last_ch].
  - last_ch updates to c on each window access at S5.
- Simultaneous events:
  - Only one bus access occurs per cycle.
  - Each channel's pipeline is independent, so different channels may step in the same cycle.
- Reset mid-step: all pending flags are discarded and the pointer reads 0.

Decomposition:
- Shared package ramdisk_pkg:
  - Register offset constants (OFS_L=0, OFS_M=1, OFS_H=2, OFS_WIN=3, REG_MODE=4'hC).
  - Step-mode encodings.
  - State constants S_SYNC=1 through S_STALL=7.
- One sub-module, ramdisk_ptr_chan:
  - Holds one channel's pointer bytes, its pend flags and step_dir.
  - Implements the S1-S3 pipeline and the carry compensation.
  - Instantiated NCH times via generate.
- The top level keeps the sequencer, the address decode, the MODE register and the muxes.

Test Plan:
- Sync and enable: toggle PHI1 with 7 C7M cycles per half-phase, IOSEL access at S4. Expect S sequence 1..7 then resync to 1, REGEN=1, and CSDBEN high during S5-S7 plus the following S1.
- Increment carry: NCH=2, ADDR_W=20, ch1 pointer=0x0FFFF, MODE=0. Read 0x7, then idle one cycle. Expect ch1=0x10000, with RA showing each byte step at S1/S2/S3.
- Decrement and wrap: ch0=0x00000, MODE=01. One window access. Expect ch0=0xFFFFF; high-byte readback 0xFF.
- Hold mode and mode latch: ch0 window access in MODE=00, then write MODE=10 in the next cycle's S5. Expect ch0 stepped +1 exactly once; a further window access leaves it unchanged.
- Carry compensation: ch0 L=0x80, MODE=0. Write 0x00 to 0x0. Expect M incremented by 1 in the next cycle; with decrement mode, L=0x7F, write 0x80 gives M-1.
- Unmapped and reset: NCH=2, access 0x8-0xB and 0xD. Expect Dout=0x00, RAMSEL=0, no state change. Assert RES during a pending step: expect all pointers 0, no step after release.
